// File: rtl/uart_rx_parity.sv
// UART receiver: 2-FF synchronised RX, start/8 data/optional parity/stop framing, with parity and framing error flags.
// Define UART_RX_PARITY_EN to include the parity bit (8x1 framing); leave it undefined for 8N1 with PARITY_ERR tied low.
module uart_rx_parity #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_DONE    = 3'd5,
    S_RECOVER = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_bit_q, stop_bit_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_q, par_bit_d;
  logic            parity_err_q, parity_err_d;

  function automatic logic parity_mismatch(input logic [7:0] d, input logic p);
    return p != ((^d) ^ ODD);
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    stop_bit_d   = stop_bit_q;
    rx_meta_d    = RX;
    rx_s_d       = rx_meta_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          timer_d   = '0;
          bit_idx_d = 3'd0;
        end
      end
      // Half a bit into the start bit: a high line here means it was a glitch.
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d    = '0;
          stop_bit_d = rx_s_q;
          state_d    = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        data_out_d   = shift_q;
        frame_err_d  = ~stop_bit_q;
        data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_mismatch(shift_q, par_bit_q);
`endif
        state_d = stop_bit_q ? S_IDLE : S_RECOVER;
      end
      // A held-low line after a bad stop bit must not be taken as a new start bit.
      S_RECOVER: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    shift_q    <= shift_d;
    stop_bit_q <= stop_bit_d;
`ifdef UART_RX_PARITY_EN
    par_bit_q  <= par_bit_d;
`endif
    if (RST) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= 3'd0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = parity_err_q;
`else
  // No parity bit on the wire, so the flag can never be raised.
  assign PARITY_ERR = ODD & 1'b0;
`endif

endmodule
